mult_scheduler: RTL and testbench

- Round-robin front end that shares one `multiplier` instance (64-entry write/read block, 16x16 operands) between two requesters.
- Accepts operand pairs from requester 0 and requester 1 through valid/ready handshakes and issues at most 64 operations per block.
- Records which requester issued each entry, triggers the block read once the multiplier reports full, and returns each product tagged with its requester and entry index.

---
 rtl/mult_scheduler_if.sv | 41 ++++
 rtl/mult_scheduler.sv | 137 +++++++++++++
 tb/tb_mult_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_scheduler_if.sv
// Bundles the two requester handshakes, the shared multiplier interface and the tagged result stream.
// The slave modport is the scheduler's view; the master modport is the surrounding system's view.
interface mult_scheduler_if #(
  parameter int N = 32
);
  logic          req0_valid;
  logic [15:0]   req0_a;
  logic [15:0]   req0_b;
  logic          req0_ready;
  logic          req1_valid;
  logic [15:0]   req1_a;
  logic [15:0]   req1_b;
  logic          req1_ready;
  logic          RDY_mult;
  logic          EN_mult;
  logic [15:0]   mult_input0;
  logic [15:0]   mult_input1;
  logic          EN_blockRead;
  logic          VALID_memVal;
  logic [N-1:0]  memVal_data;
  logic          res_valid;
  logic [N-1:0]  res_data;
  logic          res_tag;
  logic [5:0]    res_index;
  logic [6:0]    issue_count;
  logic          busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  RDY_mult, VALID_memVal, memVal_data,
    output req0_ready, req1_ready, EN_mult, mult_input0, mult_input1, EN_blockRead,
    output res_valid, res_data, res_tag, res_index, issue_count, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output RDY_mult, VALID_memVal, memVal_data,
    input  req0_ready, req1_ready, EN_mult, mult_input0, mult_input1, EN_blockRead,
    input  res_valid, res_data, res_tag, res_index, issue_count, busy
  );
endinterface

// File: rtl/mult_scheduler.sv
// Round-robin front end sharing one block-oriented multiplier between two requesters,
// returning each product tagged with the requester that issued it and its entry index.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ISSUE     | granting operand pairs until the block holds DEPTH entries
//   WAIT_FULL | block full, waiting for the multiplier to drop RDY_mult
//   DRAIN_REQ | one-cycle EN_blockRead pulse
//   DRAIN     | tagging and forwarding read-back beats until the last index
module mult_scheduler #(
  parameter int N     = 32,
  parameter int DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst,
  mult_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    ISSUE,
    WAIT_FULL,
    DRAIN_REQ,
    DRAIN
  } state_e;

  localparam logic [6:0] CAP      = 7'(DEPTH);
  localparam logic [5:0] LAST_IDX = 6'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [6:0]    issue_count_q, issue_count_d;
  logic [5:0]    res_idx_q, res_idx_d;
  logic          prefer1_q, prefer1_d;
  logic          tag_mem_q [DEPTH];

  logic          res_valid_q;
  logic [N-1:0]  res_data_q;
  logic          res_tag_q;
  logic [5:0]    res_index_q;

  logic          can_grant;
  logic          grant0;
  logic          grant1;
  logic          beat;
  logic          blk_read;

  // Grant is gated by rst so nothing is accepted while the scheduler is held in reset.
  always_comb begin
    can_grant = 1'b0;
    grant0    = 1'b0;
    grant1    = 1'b0;
    can_grant = !rst && (state_q == ISSUE) && bus.RDY_mult && (issue_count_q < CAP);
    grant1    = can_grant && bus.req1_valid && (!bus.req0_valid || prefer1_q);
    grant0    = can_grant && bus.req0_valid && !grant1;
  end

  assign beat = (state_q == DRAIN) && bus.VALID_memVal;

  always_comb begin
    state_d       = state_q;
    issue_count_d = issue_count_q;
    res_idx_d     = res_idx_q;
    prefer1_d     = prefer1_q;
    blk_read      = 1'b0;

    if (grant0 || grant1) begin
      issue_count_d = issue_count_q + 7'd1;
      prefer1_d     = grant0;
    end

    case (state_q)
      ISSUE: begin
        if (issue_count_d == CAP) state_d = WAIT_FULL;
      end
      WAIT_FULL: begin
        if (!bus.RDY_mult) state_d = DRAIN_REQ;
      end
      DRAIN_REQ: begin
        blk_read = 1'b1;
        state_d  = DRAIN;
      end
      DRAIN: begin
        if (beat) begin
          res_idx_d = res_idx_q + 6'd1;
          if (res_idx_q == LAST_IDX) begin
            res_idx_d     = 6'd0;
            issue_count_d = 7'd0;
            state_d       = ISSUE;
          end
        end
      end
      default: state_d = ISSUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ISSUE;
      issue_count_q <= 7'd0;
      res_idx_q     <= 6'd0;
      prefer1_q     <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_tag_q     <= 1'b0;
      res_index_q   <= 6'd0;
    end else begin
      state_q       <= state_d;
      issue_count_q <= issue_count_d;
      res_idx_q     <= res_idx_d;
      prefer1_q     <= prefer1_d;
      res_valid_q   <= beat;
      if (beat) begin
        res_data_q  <= bus.memVal_data;
        res_tag_q   <= tag_mem_q[res_idx_q];
        res_index_q <= res_idx_q;
      end
    end
  end

  // Tag contents are don't-care after reset, so the store carries no reset.
  always_ff @(posedge clk) begin
    if (grant0 || grant1) tag_mem_q[issue_count_q[5:0]] <= grant1;
  end

  assign bus.req0_ready   = grant0;
  assign bus.req1_ready   = grant1;
  assign bus.EN_mult      = grant0 || grant1;
  assign bus.mult_input0  = grant1 ? bus.req1_a : (grant0 ? bus.req0_a : 16'd0);
  assign bus.mult_input1  = grant1 ? bus.req1_b : (grant0 ? bus.req0_b : 16'd0);
  assign bus.EN_blockRead = blk_read && !rst;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_tag      = res_tag_q;
  assign bus.res_index    = res_index_q;
  assign bus.issue_count  = issue_count_q;
  assign bus.busy         = (state_q != ISSUE);

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed bench for mult_scheduler: grant vectors from a table, then whole issue/drain blocks
// with a scoreboard of expected tags and products.
module tb_mult_scheduler;

  logic clk;
  logic rst;

  mult_scheduler_if #(.N(32)) bus ();

  mult_scheduler #(.N(32), .DEPTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [15:0] a0;
    logic [15:0] b0;
    logic        v1;
    logic [15:0] a1;
    logic [15:0] b1;
    logic        rdy;
    logic        e_r0;
    logic        e_r1;
    logic        e_en;
    logic [15:0] e_in0;
    logic [15:0] e_in1;
  } vec_t;

  vec_t        tbl [10];
  int          tests = 0;
  int          fails = 0;
  int          cnt_m = 0;
  logic        prefer1_m = 1'b0;
  logic        exp_tag [64];
  logic [31:0] exp_prod [64];
  int          gcnt0 = 0;
  int          gcnt1 = 0;
  int          en_cnt = 0;
  int          br_cnt = 0;
  int          en_base;
  int          br_base;

  always @(negedge clk) begin
    if (bus.EN_mult) en_cnt++;
    if (bus.EN_blockRead) br_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_idle();
    bus.req0_valid   = 1'b0;
    bus.req0_a       = 16'd0;
    bus.req0_b       = 16'd0;
    bus.req1_valid   = 1'b0;
    bus.req1_a       = 16'd0;
    bus.req1_b       = 16'd0;
    bus.RDY_mult     = 1'b0;
    bus.VALID_memVal = 1'b0;
    bus.memVal_data  = 32'd0;
  endtask

  task automatic model_reset();
    cnt_m     = 0;
    prefer1_m = 1'b0;
  endtask

  // One issue-phase cycle: drive at posedge+1, check at negedge, advance past the next edge.
  task automatic apply(input vec_t v, input string nm);
    bus.req0_valid = v.v0;
    bus.req0_a     = v.a0;
    bus.req0_b     = v.b0;
    bus.req1_valid = v.v1;
    bus.req1_a     = v.a1;
    bus.req1_b     = v.b1;
    bus.RDY_mult   = v.rdy;
    @(negedge clk);
    chk({nm, ".cnt"}, 32'(bus.issue_count), 32'(cnt_m));
    chk({nm, ".rdy0"}, 32'(bus.req0_ready), 32'(v.e_r0));
    chk({nm, ".rdy1"}, 32'(bus.req1_ready), 32'(v.e_r1));
    chk({nm, ".en"}, 32'(bus.EN_mult), 32'(v.e_en));
    chk({nm, ".in0"}, 32'(bus.mult_input0), 32'(v.e_in0));
    chk({nm, ".in1"}, 32'(bus.mult_input1), 32'(v.e_in1));
    if (v.e_en && cnt_m < 64) begin
      exp_tag[cnt_m]  = v.e_r1;
      exp_prod[cnt_m] = v.e_r1 ? 32'(v.a1) * 32'(v.b1) : 32'(v.a0) * 32'(v.b0);
      cnt_m++;
      prefer1_m = v.e_r0;
      if (v.e_r1) gcnt1++;
      else gcnt0++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v0, input logic [15:0] a0, input logic [15:0] b0,
                       input logic v1, input logic [15:0] a1, input logic [15:0] b1,
                       input logic rdy);
    vec_t v;
    logic can;
    can     = rdy && (cnt_m < 64);
    v.v0    = v0;  v.a0 = a0;  v.b0 = b0;
    v.v1    = v1;  v.a1 = a1;  v.b1 = b1;
    v.rdy   = rdy;
    v.e_r1  = can && v1 && (!v0 || prefer1_m);
    v.e_r0  = can && v0 && !v.e_r1;
    v.e_en  = v.e_r0 || v.e_r1;
    v.e_in0 = v.e_r1 ? a1 : (v.e_r0 ? a0 : 16'd0);
    v.e_in1 = v.e_r1 ? b1 : (v.e_r0 ? b0 : 16'd0);
    apply(v, "iss");
  endtask

  // Entered just after the edge that issued entry 63; requester inputs are left as the caller set them.
  task automatic drain(input int guard, input int n, input bit gaps);
    chk("wf.busy", 32'(bus.busy), 32'd1);
    chk("wf.cnt", 32'(bus.issue_count), 32'd64);
    bus.RDY_mult = 1'b1;
    for (int g = 0; g < guard; g++) begin
      @(negedge clk);
      chk("guard.en", 32'(bus.EN_mult), 32'd0);
      chk("guard.rdy0", 32'(bus.req0_ready), 32'd0);
      chk("guard.rdy1", 32'(bus.req1_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.RDY_mult = 1'b0;
    @(negedge clk);
    chk("wf.blk", 32'(bus.EN_blockRead), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("dreq.blk", 32'(bus.EN_blockRead), 32'd1);
    chk("dreq.busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("drain.blk", 32'(bus.EN_blockRead), 32'd0);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 5 == 2)) begin
        bus.VALID_memVal = 1'b0;
        @(posedge clk);
        #1;
        chk("gap.valid", 32'(bus.res_valid), 32'd0);
      end
      bus.VALID_memVal = 1'b1;
      bus.memVal_data  = exp_prod[i];
      @(posedge clk);
      #1;
      chk("res.valid", 32'(bus.res_valid), 32'd1);
      chk("res.data", bus.res_data, exp_prod[i]);
      chk("res.tag", 32'(bus.res_tag), 32'(exp_tag[i]));
      chk("res.index", 32'(bus.res_index), 32'(i));
      chk("drain.rdy0", 32'(bus.req0_ready), 32'd0);
      chk("drain.rdy1", 32'(bus.req1_ready), 32'd0);
      chk("drain.en", 32'(bus.EN_mult), 32'd0);
    end
    bus.VALID_memVal = 1'b0;
    if (n == 64) begin
      chk("end.busy", 32'(bus.busy), 32'd0);
      chk("end.cnt", 32'(bus.issue_count), 32'd0);
      cnt_m = 0;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    //            v0    a0     b0     v1    a1     b1     rdy   r0    r1    en    in0    in1
    tbl[0] = '{1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[1] = '{1'b1, 16'd5, 16'd7, 1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd5, 16'd7};
    tbl[2] = '{1'b1, 16'd2, 16'd3, 1'b1, 16'd4, 16'd6, 1'b1, 1'b0, 1'b1, 1'b1, 16'd4, 16'd6};
    tbl[3] = '{1'b1, 16'd2, 16'd3, 1'b1, 16'd4, 16'd6, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2, 16'd3};
    tbl[4] = '{1'b1, 16'd2, 16'd3, 1'b1, 16'd4, 16'd6, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[5] = '{1'b0, 16'd0, 16'd0, 1'b1, 16'd9, 16'd9, 1'b1, 1'b0, 1'b1, 1'b1, 16'd9, 16'd9};
    tbl[6] = '{1'b0, 16'd0, 16'd0, 1'b1, 16'd9, 16'd9, 1'b1, 1'b0, 1'b1, 1'b1, 16'd9, 16'd9};
    tbl[7] = '{1'b1, 16'd2, 16'd3, 1'b1, 16'd4, 16'd6, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2, 16'd3};
    tbl[8] = '{1'b1, 16'd2, 16'd3, 1'b1, 16'd4, 16'd6, 1'b1, 1'b0, 1'b1, 1'b1, 16'd4, 16'd6};
    tbl[9] = '{1'b1, 16'd5, 16'd7, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};

    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.req0_valid = 1'b1;
    bus.req0_a     = 16'd5;
    bus.req1_valid = 1'b1;
    bus.RDY_mult   = 1'b1;
    @(negedge clk);
    chk("rst.rdy0", 32'(bus.req0_ready), 32'd0);
    chk("rst.rdy1", 32'(bus.req1_ready), 32'd0);
    chk("rst.en", 32'(bus.EN_mult), 32'd0);
    chk("rst.res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst.res_data", bus.res_data, 32'd0);
    chk("rst.res_tag", 32'(bus.res_tag), 32'd0);
    chk("rst.res_index", 32'(bus.res_index), 32'd0);
    chk("rst.cnt", 32'(bus.issue_count), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.blk", 32'(bus.EN_blockRead), 32'd0);
    @(posedge clk);
    #1;
    set_idle();
    rst = 1'b0;
    model_reset();

    // Block 1: table vectors, then fill the rest from requester 0.
    for (int i = 0; i < 10; i++) apply(tbl[i], $sformatf("vec%0d", i));
    while (cnt_m < 64) issue(1'b1, 16'(100 + cnt_m), 16'd3, 1'b0, 16'd0, 16'd0, 1'b1);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    drain(5, 64, 1'b1);
    set_idle();
    @(posedge clk);
    #1;
    chk("b1.after.valid", 32'(bus.res_valid), 32'd0);

    // Block 2: req0 streams a=i, b=2; a 65th pair waits through the guard window.
    en_base = en_cnt;
    br_base = br_cnt;
    for (int i = 0; i < 64; i++) issue(1'b1, 16'(i), 16'd2, 1'b0, 16'd0, 16'd0, 1'b1);
    bus.req0_valid = 1'b1;
    bus.req0_a     = 16'd64;
    bus.req1_valid = 1'b1;
    drain(5, 64, 1'b0);
    chk("b2.prod63", exp_prod[63], 32'd126);
    chk("b2.en_pulses", 32'(en_cnt - en_base), 32'd64);
    chk("b2.blk_pulses", 32'(br_cnt - br_base), 32'd1);
    set_idle();
    @(posedge clk);
    #1;

    // Block 3: both requesters always valid from a fresh reset.
    pulse_reset();
    gcnt0 = 0;
    gcnt1 = 0;
    for (int k = 0; k < 64; k++) begin
      issue(1'b1, 16'd1, 16'(k), 1'b1, 16'd3, 16'(k), 1'b1);
      chk("b3.alt_tag", 32'(exp_tag[k]), 32'(k % 2));
    end
    chk("b3.grants0", 32'(gcnt0), 32'd32);
    chk("b3.grants1", 32'(gcnt1), 32'd32);
    drain(0, 64, 1'b1);
    set_idle();

    // Block 4: bursty req1, then req0 held valid across WAIT_FULL/DRAIN.
    for (int i = 0; i < 64; i++) begin
      issue(1'b0, 16'd0, 16'd0, 1'b1, 16'(i + 1), 16'd7, 1'b1);
      if (i < 63) begin
        for (int g = 0; g < 3; g++) issue(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b1);
      end
    end
    bus.req0_valid = 1'b1;
    bus.req0_a     = 16'd7;
    bus.req0_b     = 16'd8;
    drain(2, 64, 1'b0);
    issue(1'b1, 16'd7, 16'd8, 1'b0, 16'd0, 16'd0, 1'b1);
    chk("b4.regrant_cnt", 32'(bus.issue_count), 32'd1);
    chk("b4.after.valid", 32'(bus.res_valid), 32'd0);

    // Block 5: fill, then reset partway through the drain.
    while (cnt_m < 64) issue(1'b1, 16'(10 + cnt_m), 16'd5, 1'b0, 16'd0, 16'd0, 1'b1);
    set_idle();
    drain(0, 21, 1'b0);
    chk("b5.last_idx", 32'(bus.res_index), 32'd20);
    bus.VALID_memVal = 1'b1;
    bus.memVal_data  = 32'h1234;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("mrst.valid", 32'(bus.res_valid), 32'd0);
    chk("mrst.cnt", 32'(bus.issue_count), 32'd0);
    chk("mrst.busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("mrst.ignored", 32'(bus.res_valid), 32'd0);
      chk("mrst.busy2", 32'(bus.busy), 32'd0);
    end
    bus.VALID_memVal = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
